coin_vend_ctrl: RTL and testbench

Parametrised coin-acceptor and vend controller with N coin channels of configurable denomination. It accumulates credit against a latched price and tracks per-channel coin counts. It issues a one-cycle vend or refund with a registered change amount, under a 4-state FSM. It sits between the coin-sensor pulse conditioners and the dispenser/change-return logic.

---
 rtl/coin_pkg.sv | 18 +
 rtl/coin_chan_counter.sv | 20 ++
 rtl/coin_vend_ctrl.sv | 101 ++++++++++
 tb/tb_coin_vend_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/coin_pkg.sv
// rtl/coin_pkg.sv - shared types and default constants for the coin vend controller
package coin_pkg;

    localparam int DEF_VAL_W = 20;
    localparam int DEF_CNT_W = 9;

    localparam logic [DEF_VAL_W-1:0] DEN_1000 = 20'd1000;
    localparam logic [DEF_VAL_W-1:0] DEN_2000 = 20'd2000;
    localparam logic [DEF_VAL_W-1:0] DEN_5000 = 20'd5000;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_VEND    = 2'd2,
        S_REFUND  = 2'd3
    } coin_state_t;

endpackage

// File: rtl/coin_chan_counter.sv
// rtl/coin_chan_counter.sv - per-channel saturating coin counter with synchronous clear
module coin_chan_counter #(
    parameter int CNT_W = coin_pkg::DEF_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clock) begin
        if (reset || clr) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/coin_vend_ctrl.sv
// rtl/coin_vend_ctrl.sv - coin acceptor: weighted credit accumulation and vend/refund FSM
module coin_vend_ctrl
    import coin_pkg::*;
#(
    parameter int NUM_COIN = 3,
    parameter int VAL_W    = DEF_VAL_W,
    parameter int CNT_W    = DEF_CNT_W,
    parameter logic [NUM_COIN*VAL_W-1:0] DENOMS = {DEN_5000, DEN_2000, DEN_1000}
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_COIN-1:0]       coin_pulse,
    input  logic [VAL_W-1:0]          price,
    input  logic                      start,
    input  logic                      cancel,
    output logic                      busy,
    output logic [VAL_W-1:0]          credit,
    output logic [NUM_COIN*CNT_W-1:0] coin_cnt,
    output logic                      vend,
    output logic                      refund,
    output logic [VAL_W-1:0]          change_amount,
    output logic                      coin_reject
);

    // Four guard bits cover the sum of up to eight full-scale channels plus the running credit.
    localparam int SUM_W = VAL_W + 4;

    coin_state_t      state;
    logic [VAL_W-1:0] price_q;
    logic [SUM_W-1:0] coin_sum;
    logic [SUM_W-1:0] credit_sum;
    logic [VAL_W-1:0] credit_next;
    logic             cnt_clr;

    always_comb begin
        coin_sum = '0;
        for (int i = 0; i < NUM_COIN; i++) begin
            if (coin_pulse[i]) begin
                coin_sum = coin_sum + {4'd0, DENOMS[i*VAL_W +: VAL_W]};
            end
        end
    end

    assign credit_sum  = {4'd0, credit} + coin_sum;
    assign credit_next = (|credit_sum[SUM_W-1:VAL_W]) ? {VAL_W{1'b1}} : credit_sum[VAL_W-1:0];
    assign cnt_clr     = (state == S_IDLE) && start;
    assign busy        = (state != S_IDLE);

    for (genvar g = 0; g < NUM_COIN; g++) begin : g_chan
        coin_chan_counter #(.CNT_W(CNT_W)) u_cnt (
            .clock (clock),
            .reset (reset),
            .clr   (cnt_clr),
            .inc   ((state == S_COLLECT) && coin_pulse[g]),
            .count (coin_cnt[g*CNT_W +: CNT_W])
        );
    end

    // The exit decision uses the registered credit, but change includes any coin landing that same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= S_IDLE;
            price_q       <= '0;
            credit        <= '0;
            vend          <= 1'b0;
            refund        <= 1'b0;
            change_amount <= '0;
            coin_reject   <= 1'b0;
        end else begin
            vend          <= 1'b0;
            refund        <= 1'b0;
            change_amount <= '0;
            coin_reject   <= (|coin_pulse) && (state != S_COLLECT);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        price_q <= price;
                        credit  <= '0;
                        state   <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    credit <= credit_next;
                    if (credit >= price_q) begin
                        state         <= S_VEND;
                        vend          <= 1'b1;
                        change_amount <= credit_next - price_q;
                    end else if (cancel) begin
                        state         <= S_REFUND;
                        refund        <= 1'b1;
                        change_amount <= credit_next;
                    end
                end
                S_VEND:   state <= S_IDLE;
                S_REFUND: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_coin_vend_ctrl.sv
// tb/tb_coin_vend_ctrl.sv - directed self-checking bench for coin_vend_ctrl
module tb_coin_vend_ctrl;

    localparam int NUM_COIN = 3;
    localparam int VAL_W    = 20;
    localparam int CNT_W    = 9;

    logic                      clock = 1'b0;
    logic                      reset;
    logic [NUM_COIN-1:0]       coin_pulse;
    logic [VAL_W-1:0]          price;
    logic                      start;
    logic                      cancel;
    logic                      busy;
    logic [VAL_W-1:0]          credit;
    logic [NUM_COIN*CNT_W-1:0] coin_cnt;
    logic                      vend;
    logic                      refund;
    logic [VAL_W-1:0]          change_amount;
    logic                      coin_reject;

    int n_checks = 0;
    int n_pass   = 0;

    coin_vend_ctrl #(
        .NUM_COIN (NUM_COIN),
        .VAL_W    (VAL_W),
        .CNT_W    (CNT_W),
        .DENOMS   ({20'd5000, 20'd2000, 20'd1000})
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .coin_pulse    (coin_pulse),
        .price         (price),
        .start         (start),
        .cancel        (cancel),
        .busy          (busy),
        .credit        (credit),
        .coin_cnt      (coin_cnt),
        .vend          (vend),
        .refund        (refund),
        .change_amount (change_amount),
        .coin_reject   (coin_reject)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; coin_pulse = '0; price = '0; start = 1'b0; cancel = 1'b0;
        tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_credit", credit, 0);
        check("rst_cnt", coin_cnt, 0);
        check("rst_vend", vend, 0);
        check("rst_refund", refund, 0);
        check("rst_change", change_amount, 0);
        check("rst_reject", coin_reject, 0);
        reset = 1'b0;

        // price 6000: ch2 then ch0 two cycles later
        price = 20'd6000; start = 1'b1; tick(); start = 1'b0;
        check("t1_busy", busy, 1);
        check("t1_credit0", credit, 0);
        coin_pulse = 3'b100; tick(); coin_pulse = '0;
        check("t1_credit5000", credit, 5000);
        tick();
        coin_pulse = 3'b001; tick(); coin_pulse = '0;
        check("t1_credit6000", credit, 6000);
        check("t1_novend_early", vend, 0);
        tick();
        check("t1_vend", vend, 1);
        check("t1_change", change_amount, 0);
        check("t1_cnt", coin_cnt, {9'd1, 9'd0, 9'd1});
        tick();
        check("t1_vend_drop", vend, 0);
        check("t1_idle", busy, 0);
        check("t1_change_zero", change_amount, 0);
        check("t1_credit_hold", credit, 6000);

        // price 3000, single ch2 coin
        price = 20'd3000; start = 1'b1; tick(); start = 1'b0;
        check("t2_cnt_clr", coin_cnt, 0);
        coin_pulse = 3'b100; tick(); coin_pulse = '0;
        tick();
        check("t2_vend", vend, 1);
        check("t2_change", change_amount, 2000);
        check("t2_busy_in_vend", busy, 1);
        tick();
        check("t2_busy_drop", busy, 0);

        // price 3000, ch0+ch1 same cycle
        price = 20'd3000; start = 1'b1; tick(); start = 1'b0;
        coin_pulse = 3'b011; tick(); coin_pulse = '0;
        check("t3_credit", credit, 3000);
        check("t3_novend", vend, 0);
        tick();
        check("t3_vend", vend, 1);
        check("t3_change", change_amount, 0);
        tick();

        // price 7000, ch1 then cancel
        price = 20'd7000; start = 1'b1; tick(); start = 1'b0;
        coin_pulse = 3'b010; tick(); coin_pulse = '0;
        check("t4_credit", credit, 2000);
        cancel = 1'b1; tick(); cancel = 1'b0;
        check("t4_refund", refund, 1);
        check("t4_change", change_amount, 2000);
        check("t4_novend", vend, 0);
        tick();
        check("t4_refund_drop", refund, 0);
        check("t4_novend2", vend, 0);
        check("t4_idle", busy, 0);

        // coin while idle, from a clean reset
        reset = 1'b1; tick(); reset = 1'b0;
        coin_pulse = 3'b100; tick(); coin_pulse = '0;
        check("t5_reject", coin_reject, 1);
        check("t5_credit", credit, 0);
        check("t5_busy", busy, 0);
        tick();
        check("t5_reject_drop", coin_reject, 0);

        // reset mid-transaction, then zero price
        price = 20'd9000; start = 1'b1; tick(); start = 1'b0;
        coin_pulse = 3'b100; tick(); coin_pulse = '0;
        check("t6_credit", credit, 5000);
        reset = 1'b1; tick(); reset = 1'b0;
        check("t6_busy", busy, 0);
        check("t6_credit0", credit, 0);
        check("t6_cnt0", coin_cnt, 0);
        check("t6_vend", vend, 0);
        check("t6_refund", refund, 0);
        check("t6_change", change_amount, 0);
        price = 20'd0; start = 1'b1; tick(); start = 1'b0;
        check("t6_collect_novend", vend, 0);
        tick();
        check("t6_vend0", vend, 1);
        check("t6_change0", change_amount, 0);
        tick();

        // saturation: 520 ch0 coins, then 76 cycles of ch1+ch2 (7000 each)
        price = 20'hFFFFF; start = 1'b1; tick(); start = 1'b0;
        coin_pulse = 3'b001;
        for (int i = 0; i < 520; i++) tick();
        coin_pulse = '0;
        check("t7_cnt0_sat", coin_cnt[CNT_W-1:0], 511);
        check("t7_credit520k", credit, 520000);
        coin_pulse = 3'b110;
        for (int i = 0; i < 76; i++) tick();
        coin_pulse = '0;
        check("t7_credit_sat", credit, 20'hFFFFF);
        check("t7_novend_yet", vend, 0);
        tick();
        check("t7_vend", vend, 1);
        check("t7_change", change_amount, 0);
        check("t7_cnt_hi", coin_cnt[NUM_COIN*CNT_W-1:CNT_W], {9'd76, 9'd76});
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
